// File: rtl/fetch_bp.sv
// Instruction-fetch stage with a bimodal (2-bit saturating counter) branch predictor.
// Drives the IF/ID register; redirects from later stages override stall and flush.
module fetch_bp #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned BHT_LOG2 = 6,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        keep,
   input  logic        nop,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        bht_update_valid,
   input  logic [31:0] bht_update_pc,
   input  logic        bht_update_taken,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PC_pype0,
   output logic [31:0] PCp4_pype0,
   output logic [31:0] Instraction_pype,
   output logic        is_branch_predict_pype0
);

   localparam int unsigned BHT_SIZE = 1 << BHT_LOG2;

   logic [31:0] pc_q, pc_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic [31:0] if_pc4_q, if_pc4_d;
   logic [31:0] if_inst_q, if_inst_d;
   logic        if_pred_q, if_pred_d;
   logic [1:0]  bht_q [BHT_SIZE];
   logic [1:0]  bht_d [BHT_SIZE];

   logic [6:0]          opcode;
   logic [31:0]         b_imm, j_imm, pc_plus4, target, next_pc;
   logic                predict;
   logic [BHT_LOG2-1:0] fetch_idx, upd_idx;
   logic                unused_upd_bits;

   assign unused_upd_bits = ^{bht_update_pc[31:BHT_LOG2+2], bht_update_pc[1:0]};

   assign imem_addr               = pc_q;
   assign PC_pype0                = if_pc_q;
   assign PCp4_pype0              = if_pc4_q;
   assign Instraction_pype        = if_inst_q;
   assign is_branch_predict_pype0 = if_pred_q;

   always_comb begin
      opcode    = imem_rdata[6:0];
      b_imm     = {{20{imem_rdata[31]}}, imem_rdata[7], imem_rdata[30:25],
                   imem_rdata[11:8], 1'b0};
      j_imm     = {{12{imem_rdata[31]}}, imem_rdata[19:12], imem_rdata[20],
                   imem_rdata[30:21], 1'b0};
      fetch_idx = pc_q[BHT_LOG2+1:2];
      upd_idx   = bht_update_pc[BHT_LOG2+1:2];
      pc_plus4  = pc_q + 32'd4;
      predict   = 1'b0;
      target    = pc_plus4;

      // Predecode: conditional branches consult the BHT, JAL is always taken
      case (opcode)
         7'b1100011: begin
            predict = bht_q[fetch_idx][1];
            target  = pc_q + b_imm;
         end
         7'b1101111: begin
            predict = 1'b1;
            target  = pc_q + j_imm;
         end
         default: begin
            predict = 1'b0;
            target  = pc_plus4;
         end
      endcase
      next_pc = predict ? target : pc_plus4;

      pc_d      = pc_q;
      if_pc_d   = if_pc_q;
      if_pc4_d  = if_pc4_q;
      if_inst_d = if_inst_q;
      if_pred_d = if_pred_q;

      if (redirect_valid) begin
         pc_d      = redirect_pc;
         if_pc_d   = 32'd0;
         if_pc4_d  = 32'd0;
         if_inst_d = NOP_INST;
         if_pred_d = 1'b0;
      end else if (keep) begin
         pc_d = pc_q;
      end else if (nop) begin
         if_pc_d   = 32'd0;
         if_pc4_d  = 32'd0;
         if_inst_d = NOP_INST;
         if_pred_d = 1'b0;
      end else begin
         pc_d      = next_pc;
         if_pc_d   = pc_q;
         if_pc4_d  = pc_plus4;
         if_inst_d = imem_rdata;
         if_pred_d = predict;
      end

      // Training is independent of the pipeline controls
      bht_d = bht_q;
      if (bht_update_valid) begin
         if (bht_update_taken && bht_q[upd_idx] != 2'b11)
            bht_d[upd_idx] = bht_q[upd_idx] + 2'b01;
         else if (!bht_update_taken && bht_q[upd_idx] != 2'b00)
            bht_d[upd_idx] = bht_q[upd_idx] - 2'b01;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q      <= RESET_PC;
         if_pc_q   <= 32'd0;
         if_pc4_q  <= 32'd4;
         if_inst_q <= NOP_INST;
         if_pred_q <= 1'b0;
         for (int i = 0; i < int'(BHT_SIZE); i++) bht_q[i] <= 2'b01;
      end else begin
         pc_q      <= pc_d;
         if_pc_q   <= if_pc_d;
         if_pc4_q  <= if_pc4_d;
         if_inst_q <= if_inst_d;
         if_pred_q <= if_pred_d;
         bht_q     <= bht_d;
      end
   end

endmodule

// File: tb/tb_fetch_bp.sv
// Bench for fetch_bp: directed plan steps then randomized traffic, all checked
// against a behavioural model that tracks per-word branch kind and offset.
module tb_fetch_bp;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b0, keep = 1'b0, nop = 1'b0, redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        bht_update_valid = 1'b0, bht_update_taken = 1'b0;
   logic [31:0] bht_update_pc = 32'd0;
   logic [31:0] imem_addr, imem_rdata;
   logic [31:0] PC_pype0, PCp4_pype0, Instraction_pype;
   logic        is_branch_predict_pype0;

   // Instruction memory: 64 words, aliased every 256 bytes
   logic [31:0] mem [64];
   int          kind [64];
   int          offs [64];

   logic [31:0] m_pc, m_if_pc, m_if_pc4, m_if_inst;
   logic        m_if_pred;
   int          m_bht [64];

   int vectors = 0;
   int miscompares = 0;

   fetch_bp dut (
      .clk(clk), .rst(rst), .keep(keep), .nop(nop),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .bht_update_valid(bht_update_valid), .bht_update_pc(bht_update_pc),
      .bht_update_taken(bht_update_taken),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .PC_pype0(PC_pype0), .PCp4_pype0(PCp4_pype0),
      .Instraction_pype(Instraction_pype),
      .is_branch_predict_pype0(is_branch_predict_pype0)
   );

   assign imem_rdata = mem[imem_addr[7:2]];

   always #5 clk = ~clk;

   function automatic logic [31:0] enc_branch(int o);
      logic [12:0] imm;
      imm = o[12:0];
      return {imm[12], imm[10:5], 5'd2, 5'd1, 3'b000, imm[4:1], imm[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_jal(int o);
      logic [20:0] imm;
      imm = o[20:0];
      return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
   endfunction

   // kind: 0 = not control flow, 1 = conditional branch, 2 = JAL
   task automatic set_word(int idx, int k, int o, logic [31:0] other);
      kind[idx] = k;
      offs[idx] = o;
      if (k == 1) mem[idx] = enc_branch(o);
      else if (k == 2) mem[idx] = enc_jal(o);
      else mem[idx] = other;
   endtask

   task automatic model_step();
      int idx, u, tgt_off;
      bit taken;
      logic [31:0] nxt;
      if (rst) begin
         m_pc = 32'd0; m_if_pc = 32'd0; m_if_pc4 = 32'd4; m_if_inst = NOP; m_if_pred = 1'b0;
         for (int i = 0; i < 64; i++) m_bht[i] = 1;
         return;
      end
      idx     = int'(m_pc[7:2]);
      taken   = (kind[idx] == 2) || (kind[idx] == 1 && m_bht[idx] >= 2);
      tgt_off = taken ? offs[idx] : 4;
      nxt     = m_pc + 32'(tgt_off);
      if (bht_update_valid) begin
         u = int'(bht_update_pc[7:2]);
         if (bht_update_taken) m_bht[u] = (m_bht[u] == 3) ? 3 : m_bht[u] + 1;
         else                  m_bht[u] = (m_bht[u] == 0) ? 0 : m_bht[u] - 1;
      end
      if (redirect_valid) begin
         m_pc = redirect_pc;
         m_if_pc = 32'd0; m_if_pc4 = 32'd0; m_if_inst = NOP; m_if_pred = 1'b0;
      end else if (keep) begin
         m_pc = m_pc;
      end else if (nop) begin
         m_if_pc = 32'd0; m_if_pc4 = 32'd0; m_if_inst = NOP; m_if_pred = 1'b0;
      end else begin
         m_if_pc = m_pc; m_if_pc4 = m_pc + 32'd4; m_if_inst = mem[idx]; m_if_pred = taken;
         m_pc = nxt;
      end
   endtask

   task automatic checkOutput();
      vectors++;
      assert (imem_addr === m_pc) else begin
         miscompares++;
         $error("[TB] FAIL imem_addr got %h exp %h", imem_addr, m_pc);
      end
      assert (PC_pype0 === m_if_pc) else begin
         miscompares++;
         $error("[TB] FAIL PC_pype0 got %h exp %h", PC_pype0, m_if_pc);
      end
      assert (PCp4_pype0 === m_if_pc4) else begin
         miscompares++;
         $error("[TB] FAIL PCp4_pype0 got %h exp %h", PCp4_pype0, m_if_pc4);
      end
      assert (Instraction_pype === m_if_inst) else begin
         miscompares++;
         $error("[TB] FAIL Instraction_pype got %h exp %h", Instraction_pype, m_if_inst);
      end
      assert (is_branch_predict_pype0 === m_if_pred) else begin
         miscompares++;
         $error("[TB] FAIL predict got %b exp %b", is_branch_predict_pype0, m_if_pred);
      end
   endtask

   task automatic check_const(string tag, logic [31:0] got, logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(logic r, logic k, logic n, logic rv, logic [31:0] rp,
                                logic uv, logic [31:0] up, logic ut);
      @(negedge clk);
      rst = r; keep = k; nop = n; redirect_valid = rv; redirect_pc = rp;
      bht_update_valid = uv; bht_update_pc = up; bht_update_taken = ut;
      @(posedge clk);
      #1;
      model_step();
      checkOutput();
   endtask

   initial begin
      logic [31:0] rnd;
      logic [6:0]  ops [5];
      ops[0] = 7'b0010011; ops[1] = 7'b0000011; ops[2] = 7'b0100011;
      ops[3] = 7'b0110011; ops[4] = 7'b0110111;

      for (int i = 0; i < 64; i++) set_word(i, 0, 0, NOP);
      set_word(8, 1, 64, NOP);
      set_word(16, 2, -64, NOP);
      for (int i = 0; i < 64; i++) m_bht[i] = 1;
      m_pc = 32'd0; m_if_pc = 32'd0; m_if_pc4 = 32'd4; m_if_inst = NOP; m_if_pred = 1'b0;

      // Reset and sequential fetch
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      check_const("reset_pcp4", PCp4_pype0, 32'd4);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      check_const("seq_if_pc", PC_pype0, 32'h4);

      // Stall, flush, redirect over keep
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
      check_const("keep_addr", imem_addr, 32'h8);
      check_const("keep_if_pc", PC_pype0, 32'h4);
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
      check_const("nop_addr", imem_addr, 32'h8);
      check_const("nop_inst", Instraction_pype, NOP);
      applyStimulus(0, 1, 0, 1, 32'h100, 0, 0, 0);
      check_const("redir_addr", imem_addr, 32'h100);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      check_const("redir_if_pc", PC_pype0, 32'h100);

      // Train to strong-taken, then predict
      applyStimulus(0, 1, 0, 0, 0, 1, 32'h20, 1);
      applyStimulus(0, 1, 0, 0, 0, 1, 32'h20, 1);
      applyStimulus(0, 0, 0, 1, 32'h20, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      check_const("bht_taken_pred", {31'd0, is_branch_predict_pype0}, 32'd1);
      check_const("bht_taken_addr", imem_addr, 32'h60);

      // Train to strong-not-taken
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0, 1, 32'h20, 0);
      applyStimulus(0, 0, 0, 1, 32'h20, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      check_const("bht_nt_addr", imem_addr, 32'h24);

      // Same-cycle update and predict sees the old counter
      applyStimulus(0, 1, 0, 0, 0, 1, 32'h20, 1);
      applyStimulus(0, 0, 0, 1, 32'h20, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 32'h20, 1);
      check_const("same_cycle_addr", imem_addr, 32'h24);
      applyStimulus(0, 0, 0, 1, 32'h20, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      check_const("refetch_addr", imem_addr, 32'h60);

      // JAL backward and PC wrap
      applyStimulus(0, 0, 0, 1, 32'h40, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      check_const("jal_addr", imem_addr, 32'h0);
      applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      check_const("wrap_addr", imem_addr, 32'h0);
      check_const("wrap_pcp4", PCp4_pype0, 32'h0);

      // Randomized program and control traffic
      for (int i = 0; i < 64; i++) begin
         int r;
         r = int'($urandom_range(0, 9));
         rnd = $urandom();
         if (r < 4)       set_word(i, 1, int'($urandom_range(0, 2047)) * 4 - 4096, 0);
         else if (r == 4) set_word(i, 2, int'($urandom_range(0, 4095)) * 4 - 8192, 0);
         else if (r == 5) set_word(i, 0, 0, 32'h0000_8067);
         else             set_word(i, 0, 0, {rnd[31:7], ops[$urandom_range(0, 4)]});
      end
      for (int c = 0; c < 3000; c++) begin
         logic [31:0] up;
         up = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
         applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 15,
                       $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 5,
                       $urandom(), $urandom_range(0, 99) < 40, up, 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fetch_bp.md
# fetch_bp

Instruction-fetch stage with a bimodal branch predictor. It sits directly upstream of `decode` and drives the IF/ID pipeline register: `PC_pype0`, `PCp4_pype0`, `Instraction_pype` and `is_branch_predict_pype0`. Each cycle it reads one instruction from a combinational instruction memory and chooses the next PC. The next PC is PC+4, a predicted-taken branch or JAL target, or a redirect from later stages (mispredict, ecall/mret). A 2-bit saturating-counter table is trained by branch resolution from execute.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset
- BHT_LOG2, 6, log2 of predictor entries (64); index = PC[BHT_LOG2+1:2]
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, **synchronous, active-high**
- keep  in  1  stall: hold PC and IF/ID register
- nop  in  1  flush: load bubble into IF/ID register
- redirect_valid  in  1  redirect PC (mispredict, ecall, mret)
- redirect_pc  in  32  redirect target
- bht_update_valid  in  1  one-cycle pulse per resolved conditional branch
- bht_update_pc  in  32  PC of resolved branch
- bht_update_taken  in  1  actual outcome
- imem_addr  out  32  current PC, to instruction memory
- imem_rdata  in  32  instruction at imem_addr, same cycle
- PC_pype0  out  32  PC of instruction in IF/ID
- PCp4_pype0  out  32  PC+4 of that instruction
- Instraction_pype  out  32  instruction in IF/ID
- is_branch_predict_pype0  out  1  1 = fetch followed the taken path for this instruction

## Operation
- State: `pc` (32b), IF/ID register, and BHT of 2^BHT_LOG2 2-bit counters.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Predict taken iff counter[1].
- Predecode of imem_rdata:
  - opcode 1100011 (branch): predict = BHT[pc idx][1]; target = pc + B-imm (sign-extended, bit0 = 0).
  - opcode 1101111 (JAL): predict = 1 always; target = pc + J-imm.
  - all others: predict = 0. JALR is never predicted.
- next_pc = predict ? target : pc + 4. All arithmetic is 32-bit modulo; wrap-around is not flagged.
- Priority per cycle, highest first:
  1. **rst:** pc = RESET_PC; IF/ID = {0, 4, NOP_INST, 0}; every BHT entry = 01.
  2. **redirect_valid:** pc = redirect_pc; IF/ID = bubble (PC 0, PCp4 0, NOP_INST, predict 0). Overrides keep and nop.
  3. **keep:** pc and IF/ID hold.
  4. **nop:** IF/ID = bubble; pc holds.
  5. **Normal:** IF/ID = {pc, pc+4, imem_rdata, predict}; pc = next_pc.
- BHT update:
  - Applies whenever bht_update_valid=1 and rst=0, regardless of keep, nop or redirect.
  - Entry at bht_update_pc[BHT_LOG2+1:2] increments (taken) or decrements (not taken), saturating at 11 and 00.
  - No tags: aliasing is accepted.
- Same-cycle update and predict on the same index: the prediction uses the pre-update value; the new value is visible next cycle.
- Reset asserted mid-operation takes effect at that edge. In-flight updates in the same cycle are discarded.

## Timing
- imem_addr = pc combinationally. Fetch latency is 1 cycle: the instruction present at the edge appears on Instraction_pype after that edge.
- A predicted-taken branch incurs zero bubbles: its target is fetched in the next cycle.
- Redirect: the target is fetched the cycle after redirect_valid. The wrong-path instruction already in IF/ID is replaced by a bubble at the same edge.
- Reset values: imem_addr=RESET_PC, PC_pype0=0, PCp4_pype0=4, Instraction_pype=NOP_INST, is_branch_predict_pype0=0.

## Test plan
- **Reset, sequential fetch:** rst 1 cycle, imem returns addi at 0x0/0x4/0x8 → IF/ID PC = 0,4,8 on successive cycles, predict 0.
- **Stall and flush:** keep=1 for 2 cycles at pc=0x8 → PC_pype0 stays 0x4, imem_addr stays 0x8. nop=1 one cycle → Instraction_pype=0x00000013, imem_addr still 0x8.
- **Redirect beats keep:** keep=1, redirect_valid=1, redirect_pc=0x100 → next cycle imem_addr=0x100, IF/ID bubble. Following cycle PC_pype0=0x100.
- **BHT training:**
  - Branch at 0x20 with offset +0x40; two update pulses (pc 0x20, taken=1) → entry goes 01→10→11.
  - Fetch 0x20 → is_branch_predict_pype0=1, next imem_addr=0x60.
  - Three not-taken updates → 00; fetch 0x20 → predict 0, next 0x24.
- **Same-cycle update/predict:** entry at 01, fetch 0x20 with update taken in the same cycle → predict 0 that cycle. Refetch → predict 1.
- **JAL and wrap:** JAL at 0x40 with offset −0x40 → predict 1, next imem_addr=0x0. Sequential fetch at 0xFFFFFFFC → next pc 0x0.
